// File: rtl/prefix_addsub_pipe.sv
// ============================================================================
//  Module      : prefix_addsub_pipe
//  Description : Fully pipelined Kogge-Stone prefix adder/subtractor with
//                carry chaining, overflow/zero flags, tag, valid and stall.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module prefix_addsub_pipe #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LEVELS  = $clog2(WIDTH);
  localparam int LATENCY = LEVELS + 2;

  // Index 0 is the operand-conditioning stage, index k the k-th prefix level.
  logic [WIDTH-1:0] r_g   [0:LEVELS];
  logic [WIDTH-1:0] r_pp  [0:LEVELS];
  logic [WIDTH-1:0] r_p   [0:LEVELS];
  logic             r_c0  [0:LEVELS];
  logic             r_v   [0:LEVELS];
  logic [TAG_W-1:0] r_tag [0:LEVELS];

  logic [WIDTH-1:0] w_beff;
  logic             w_c0;
  logic [WIDTH-1:0] w_p0;
  logic [WIDTH-1:0] w_g0;
  logic [WIDTH-1:0] w_gn [1:LEVELS];
  logic [WIDTH-1:0] w_pn [1:LEVELS];
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_sum;

  assign in_ready = ~stall;

  // The incoming carry is folded into bit 0's generate, so the prefix tree
  // yields the true carry out of every bit directly.
  always_comb begin
    w_beff  = sub ? ~b : b;
    w_c0    = sub ? ~cin : cin;
    w_p0    = a ^ w_beff;
    w_g0    = a & w_beff;
    w_g0[0] = w_g0[0] | (w_p0[0] & w_c0);
  end

  always_comb begin
    for (int k = 1; k <= LEVELS; k++) begin
      w_gn[k] = r_g[k-1];
      w_pn[k] = r_pp[k-1];
      for (int i = (1 << (k-1)); i < WIDTH; i++) begin
        w_gn[k][i] = r_g[k-1][i] | (r_pp[k-1][i] & r_g[k-1][i-(1 << (k-1))]);
        w_pn[k][i] = r_pp[k-1][i] & r_pp[k-1][i-(1 << (k-1))];
      end
    end
  end

  assign w_carry = r_g[LEVELS];
  assign w_sum   = r_p[LEVELS] ^ {w_carry[WIDTH-2:0], r_c0[LEVELS]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= LEVELS; k++) begin
        r_g[k]   <= '0;
        r_pp[k]  <= '0;
        r_p[k]   <= '0;
        r_c0[k]  <= 1'b0;
        r_v[k]   <= 1'b0;
        r_tag[k] <= '0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      out_tag   <= '0;
    end else if (!stall) begin
      r_v[0]   <= in_valid;
      r_g[0]   <= w_g0;
      r_pp[0]  <= w_p0;
      r_p[0]   <= w_p0;
      r_c0[0]  <= w_c0;
      r_tag[0] <= in_tag;
      for (int k = 1; k <= LEVELS; k++) begin
        r_g[k]   <= w_gn[k];
        r_pp[k]  <= w_pn[k];
        r_p[k]   <= r_p[k-1];
        r_c0[k]  <= r_c0[k-1];
        r_v[k]   <= r_v[k-1];
        r_tag[k] <= r_tag[k-1];
      end
      out_valid <= r_v[LEVELS];
      // Bubbles leave the last result visible on the data outputs.
      if (r_v[LEVELS]) begin
        sum     <= w_sum;
        cout    <= w_carry[WIDTH-1];
        ovf     <= w_carry[WIDTH-1] ^ w_carry[WIDTH-2];
        zero    <= ~|w_sum;
        out_tag <= r_tag[LEVELS];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prefix_addsub_pipe.sv
// ============================================================================
//  Module      : tb_prefix_addsub_pipe
//  Description : Scoreboard bench for prefix_addsub_pipe (directed + stream).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prefix_addsub_pipe;

  localparam int WIDTH   = 64;
  localparam int TAG_W   = 4;
  localparam int LATENCY = $clog2(WIDTH) + 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             stall;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic [TAG_W-1:0] out_tag;

  prefix_addsub_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .a(a), .b(b), .cin(cin), .sub(sub), .in_tag(in_tag),
    .out_valid(out_valid), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero),
    .out_tag(out_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic [TAG_W-1:0] tag;
    int               acc;
  } exp_t;

  exp_t sb[$];
  exp_t hold;
  int   n_checks = 0;
  int   n_errors = 0;
  int   adv = 0;
  logic stall_prev = 1'b1;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [WIDTH-1:0] s, input logic c, input logic o,
                              input logic z, input logic [TAG_W-1:0] t);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.zero = z; e.tag = t; e.acc = 0;
    return e;
  endfunction

  // Reference: exact unsigned and signed arithmetic in wider words.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c, input logic s, input logic [TAG_W-1:0] t);
    logic [WIDTH:0]   full;
    logic [WIDTH+1:0] ex;
    logic [WIDTH+1:0] sx;
    logic [WIDTH+1:0] sy;
    logic [WIDTH+1:0] cc;
    exp_t e;
    sx = {{2{x[WIDTH-1]}}, x};
    sy = {{2{y[WIDTH-1]}}, y};
    cc = {{(WIDTH+1){1'b0}}, c};
    if (!s) begin
      full   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
      ex     = sx + sy + cc;
      e.cout = full[WIDTH];
    end else begin
      full   = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, c};
      ex     = sx - sy - cc;
      e.cout = ~full[WIDTH];
    end
    e.sum  = full[WIDTH-1:0];
    e.ovf  = !((ex[WIDTH+1] == ex[WIDTH]) && (ex[WIDTH] == ex[WIDTH-1]));
    e.zero = (full[WIDTH-1:0] == '0);
    e.tag  = t;
    e.acc  = 0;
    return e;
  endfunction

  always @(posedge clock) begin
    if (!reset && !stall) adv <= adv + 1;
  end

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      hold = mk('0, 1'b0, 1'b0, 1'b0, '0);
    end else if (out_valid && !stall_prev) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got sum %h tag %h, required no output", sum, out_tag);
      end else begin
        e = sb.pop_front();
        chk("sum", sum, e.sum);
        chk("cout", WIDTH'(cout), WIDTH'(e.cout));
        chk("ovf", WIDTH'(ovf), WIDTH'(e.ovf));
        chk("zero", WIDTH'(zero), WIDTH'(e.zero));
        chk("tag", WIDTH'(out_tag), WIDTH'(e.tag));
        chk("latency", WIDTH'(adv), WIDTH'(e.acc + LATENCY - 1));
        hold = e;
      end
    end else begin
      chk("hold_sum", sum, hold.sum);
      chk("hold_flags", WIDTH'({cout, ovf, zero}), WIDTH'({hold.cout, hold.ovf, hold.zero}));
      chk("hold_tag", WIDTH'(out_tag), WIDTH'(hold.tag));
    end
    stall_prev = stall;
  end

  // One cycle of stimulus; the expectation is queued only if the op is accepted.
  task automatic cyc(input logic v, input logic st, input logic [WIDTH-1:0] x,
                     input logic [WIDTH-1:0] y, input logic c, input logic s,
                     input logic [TAG_W-1:0] t, input exp_t e);
    exp_t q;
    in_valid = v; stall = st; a = x; b = y; cin = c; sub = s; in_tag = t;
    if (v && !st) begin
      q = e;
      q.acc = adv + 1;
      sb.push_back(q);
    end
    @(posedge clock); #1;
  endtask

  task automatic hand(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c,
                      input logic s, input logic [TAG_W-1:0] t, input exp_t e);
    cyc(1'b1, 1'b0, x, y, c, s, t, e);
  endtask

  task automatic idle(input logic st);
    cyc(1'b0, st, '0, '0, 1'b0, 1'b0, '0, mk('0, 1'b0, 1'b0, 1'b0, '0));
  endtask

  task automatic drain();
    in_valid = 1'b0; stall = 1'b0;
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clock); #1;
    end
    chk("drain_pending", WIDTH'(sb.size()), '0);
  endtask

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};

  initial begin
    logic [WIDTH-1:0] rx, ry;
    logic             rc, rs, rv, rst_v;
    logic [TAG_W-1:0] rt;
    int               accepted;

    reset = 1'b1; in_valid = 1'b0; stall = 1'b0; a = '0; b = '0;
    cin = 1'b0; sub = 1'b0; in_tag = '0;
    #1;
    chk("reset_out_valid", WIDTH'(out_valid), '0);
    chk("reset_sum", sum, '0);
    chk("reset_in_ready", WIDTH'(in_ready), WIDTH'(1'b1));
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Directed vectors, back to back.
    hand(ONES, 64'd1, 1'b0, 1'b0, 4'd3, mk('0, 1'b1, 1'b0, 1'b1, 4'd3));
    hand(64'd5, 64'd7, 1'b0, 1'b1, 4'd4, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 4'd4));
    hand(64'd7, 64'd5, 1'b1, 1'b1, 4'd5, mk(64'd1, 1'b1, 1'b0, 1'b0, 4'd5));
    hand(MAXP, 64'd1, 1'b0, 1'b0, 4'd6, mk(MINN, 1'b0, 1'b1, 1'b0, 4'd6));
    hand(MINN, 64'd1, 1'b0, 1'b1, 4'd7, mk(MAXP, 1'b1, 1'b1, 1'b0, 4'd7));
    hand(64'd0, 64'd0, 1'b1, 1'b0, 4'd8, mk(64'd1, 1'b0, 1'b0, 1'b0, 4'd8));
    hand(64'd0, 64'd0, 1'b0, 1'b1, 4'd9, mk('0, 1'b1, 1'b0, 1'b1, 4'd9));
    hand(ONES, ONES, 1'b1, 1'b0, 4'hA, mk(ONES, 1'b1, 1'b0, 1'b0, 4'hA));
    hand(MINN, MINN, 1'b0, 1'b0, 4'hB, mk('0, 1'b1, 1'b1, 1'b1, 4'hB));
    idle(1'b0);
    hand(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 4'hC,
         mk(64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 1'b0, 4'hC));
    // Stalled cycles with valid inputs must be ignored.
    cyc(1'b1, 1'b1, 64'd99, 64'd99, 1'b0, 1'b0, 4'hF, mk('0, 1'b0, 1'b0, 1'b0, '0));
    idle(1'b1);
    hand(64'd10, 64'd3, 1'b1, 1'b1, 4'hD, mk(64'd6, 1'b1, 1'b0, 1'b0, 4'hD));
    drain();

    // Stream with random stalls and bubbles.
    accepted = 0;
    for (int i = 0; i < 5000 && accepted < 600; i++) begin
      rx = {$urandom, $urandom};
      ry = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) ry = ~rx;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      rt = 4'($urandom_range(0, 15));
      rv = ($urandom_range(0, 99) >= 20);
      rst_v = ($urandom_range(0, 99) < 30);
      if (rv && !rst_v) accepted++;
      cyc(rv, rst_v, rx, ry, rc, rs, rt, model(rx, ry, rc, rs, rt));
    end
    drain();

    // Reset mid-run: outputs clear at once, in-flight ops vanish.
    for (int i = 0; i < 4; i++) hand(64'd100 + 64'(i), 64'd1, 1'b0, 1'b0, 4'(i), model(64'd100 + 64'(i), 64'd1, 1'b0, 1'b0, 4'(i)));
    repeat (LATENCY - 2) idle(1'b0);
    reset = 1'b1;
    sb.delete();
    #1;
    chk("t1_out_valid", WIDTH'(out_valid), '0);
    chk("t1_sum", sum, '0);
    chk("t1_flags", WIDTH'({cout, ovf, zero}), '0);
    chk("t1_tag", WIDTH'(out_tag), '0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle(1'b0);
      chk("t1_idle_valid", WIDTH'(out_valid), '0);
    end

    // Reset pulse with five ops in flight, then one op afterwards.
    for (int i = 0; i < 5; i++) hand(64'd200 + 64'(i), 64'd2, 1'b0, 1'b0, 4'(i + 1), model(64'd200 + 64'(i), 64'd2, 1'b0, 1'b0, 4'(i + 1)));
    reset = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    hand(64'd40, 64'd2, 1'b0, 1'b0, 4'hE, mk(64'd42, 1'b0, 1'b0, 1'b0, 4'hE));
    repeat (3 * LATENCY) idle(1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
